// File: rtl/ws2811_pkg.sv
// Shared WS2811/WS2812 encoder types and default timing, common to the encoder and the fader.
// Timing constants are in core clocks at 100 MHz.
package ws2811_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_GAP,
    ST_LATCH
  } enc_state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  localparam int unsigned PIXEL_BITS    = 24;
  localparam int unsigned DEF_T0H_CYC   = 30;
  localparam int unsigned DEF_T1H_CYC   = 60;
  localparam int unsigned DEF_TBIT_CYC  = 125;
  localparam int unsigned DEF_RESET_CYC = 5000;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2811_hold_reg.sv
// One-entry pixel buffer: accepted pixel visible in hold the same edge; ready is registered
// and low whenever the entry is full, so the producer stalls until the encoder takes it.
module ws2811_hold_reg
  import ws2811_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  pixel_t data,
  input  logic   last,
  input  logic   valid,
  output logic   ready,
  input  logic   take,
  output pixel_t hold,
  output logic   hold_last,
  output logic   hold_valid
);

  logic accept;
  logic valid_nxt;

  assign accept    = valid && ready;
  // A take and an accept in the same cycle leave the entry full with the new pixel.
  assign valid_nxt = accept || (hold_valid && !take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      ready      <= 1'b0;
      hold       <= '0;
      hold_last  <= 1'b0;
    end else begin
      hold_valid <= valid_nxt;
      ready      <= !valid_nxt;
      if (accept) begin
        hold      <= data;
        hold_last <= last;
      end
    end
  end

endmodule

// File: rtl/ws2811_bit_encoder.sv
// Serialises GRB pixels MSB first into the WS2811 NRZ waveform and appends the latch period.
// dout rises one edge after a pixel lands in an empty encoder; s_ready drops while a pixel is held.
module ws2811_bit_encoder
  import ws2811_pkg::*;
#(
  parameter int unsigned T0H_CYC   = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC   = DEF_T1H_CYC,
  parameter int unsigned TBIT_CYC  = DEF_TBIT_CYC,
  parameter int unsigned RESET_CYC = DEF_RESET_CYC
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [23:0] s_pixel,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int unsigned CW = $clog2(max2(TBIT_CYC, RESET_CYC) + 1);

  localparam logic [CW-1:0] T0H_END   = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] T1H_END   = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] TBIT_END  = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] RESET_END = CW'(RESET_CYC - 1);
  localparam logic [4:0]    LAST_BIT  = 5'(PIXEL_BITS - 1);

  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && RESET_CYC > 0))
  begin : g_bad_timing
    $error("ws2811_bit_encoder: need 0 < T0H_CYC < T1H_CYC < TBIT_CYC and RESET_CYC > 0");
  end

  enc_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [23:0]   shift, shift_nxt;
  logic [4:0]    bit_idx, bit_nxt;
  logic          cur_last, last_nxt;
  logic          load;
  logic          underrun_nxt;
  logic          frame_done_nxt;

  pixel_t        hold;
  logic          hold_last;
  logic          hold_valid;

  ws2811_hold_reg u_hold (
    .clk        (ACLK),
    .rst        (ARESET),
    .data       (pixel_t'(s_pixel)),
    .last       (s_last),
    .valid      (s_valid),
    .ready      (s_ready),
    .take       (load),
    .hold       (hold),
    .hold_last  (hold_last),
    .hold_valid (hold_valid)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shift      <= '0;
      bit_idx    <= '0;
      cur_last   <= 1'b0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shift      <= shift_nxt;
      bit_idx    <= bit_nxt;
      cur_last   <= last_nxt;
      underrun   <= underrun_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // cnt counts clocks from the start of the current bit period (or latch period).
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + 1'b1;
    shift_nxt      = shift;
    bit_nxt        = bit_idx;
    last_nxt       = cur_last;
    load           = 1'b0;
    underrun_nxt   = 1'b0;
    frame_done_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        load    = hold_valid;
      end
      ST_HIGH: begin
        if (cnt == (shift[23] ? T1H_END : T0H_END)) state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (cnt == TBIT_END) begin
          if (bit_idx != LAST_BIT) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = '0;
            shift_nxt = {shift[22:0], 1'b0};
            bit_nxt   = bit_idx + 5'd1;
          end else if (cur_last) begin
            state_nxt = ST_LATCH;
            cnt_nxt   = '0;
          end else if (hold_valid) begin
            load = 1'b1;
          end else begin
            underrun_nxt = 1'b1;
            state_nxt    = ST_GAP;
            cnt_nxt      = '0;
          end
        end
      end
      ST_GAP: begin
        cnt_nxt = '0;
        load    = hold_valid;
      end
      ST_LATCH: begin
        if (cnt == RESET_END) begin
          frame_done_nxt = 1'b1;
          if (hold_valid) begin
            load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Loading starts the first bit immediately, which keeps pixel boundaries seamless.
    if (load) begin
      state_nxt = ST_HIGH;
      cnt_nxt   = '0;
      shift_nxt = hold;
      bit_nxt   = '0;
      last_nxt  = hold_last;
    end
  end

  assign dout = (state == ST_HIGH);
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ws2811_bit_encoder.sv
// Directed bench for ws2811_bit_encoder: measures every high/low phase against the pixel bits,
// plus latch length, underrun, back-pressure spacing, reset and latch-overlap behaviour.
module tb_ws2811_bit_encoder;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [23:0] s_pixel = '0;
  logic        s_last = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        dout;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int und_cnt = 0;
  int fd_cnt = 0;

  ws2811_bit_encoder dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .s_pixel    (s_pixel),
    .s_last     (s_last),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (underrun === 1'b1) und_cnt <= und_cnt + 1;
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [23:0] px, input logic last, input bit keep, input int budget);
    int n = 0;
    s_pixel = px;
    s_last  = last;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    chk("send ready", s_ready, 1);
    @(negedge ACLK);
    if (!keep) s_valid = 1'b0;
  endtask

  // Starts on the first high sample of bit 23; ends one sample past the last bit period.
  task automatic run_pixel(input logic [23:0] px, input string tag);
    int hi, lo, exp_hi;
    for (int i = 23; i >= 0; i--) begin
      exp_hi = px[i] ? 60 : 30;
      hi = 0;
      while (dout === 1'b1 && hi < 100) begin
        hi++;
        @(negedge ACLK);
      end
      chk({tag, " high"}, hi, exp_hi);
      lo = 0;
      while (dout === 1'b0 && lo < 125 - exp_hi) begin
        lo++;
        @(negedge ACLK);
      end
      chk({tag, " low"}, lo, 125 - exp_hi);
    end
  endtask

  task automatic finish_frame(input string tag, input int exp_wait);
    int n = 0;
    bit saw_hi = 1'b0;
    while (frame_done !== 1'b1 && n < exp_wait + 100) begin
      if (dout !== 1'b0) saw_hi = 1'b1;
      @(negedge ACLK);
      n++;
    end
    chk({tag, " latch len"}, n, exp_wait);
    chk({tag, " latch low"}, saw_hi, 0);
  endtask

  initial begin
    int u0, f0, c1, c2, c3, n;
    bit saw_hi;

    // Reset values
    repeat (3) @(negedge ACLK);
    chk("rst dout", dout, 0);
    chk("rst s_ready", s_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst underrun", underrun, 0);
    ARESET = 1'b0;
    #1 chk("rel s_ready", s_ready, 0);
    @(negedge ACLK);
    chk("rel s_ready rise", s_ready, 1);

    // Single pixel 800001 with last
    f0 = fd_cnt;
    send(24'h800001, 1'b1, 1'b0, 50);
    chk("lat dout0", dout, 0);
    chk("lat busy0", busy, 0);
    @(negedge ACLK);
    chk("lat dout1", dout, 1);
    chk("lat busy1", busy, 1);
    run_pixel(24'h800001, "single");
    finish_frame("single", 5000);
    chk("single busy at fd", busy, 0);
    @(negedge ACLK);
    chk("single fd pulse", frame_done, 0);
    chk("single fd count", fd_cnt - f0, 1);

    // Three back-to-back pixels
    u0 = und_cnt;
    fork
      begin
        send(24'hAA5500, 1'b0, 1'b0, 4000);
        send(24'h00FF00, 1'b0, 1'b0, 4000);
        send(24'h123456, 1'b1, 1'b0, 4000);
      end
      begin
        n = 0;
        while (dout !== 1'b1 && n < 50) begin
          @(negedge ACLK);
          n++;
        end
        run_pixel(24'hAA5500, "b2b p0");
        run_pixel(24'h00FF00, "b2b p1");
        run_pixel(24'h123456, "b2b p2");
      end
    join
    finish_frame("b2b", 5000);
    chk("b2b underrun", und_cnt - u0, 0);
    @(negedge ACLK);

    // Underrun: second pixel withheld
    u0 = und_cnt;
    send(24'h0F0F0F, 1'b0, 1'b0, 50);
    @(negedge ACLK);
    run_pixel(24'h0F0F0F, "und p1");
    chk("und pulse", underrun, 1);
    saw_hi = 1'b0;
    repeat (300) begin
      @(negedge ACLK);
      if (dout !== 1'b0) saw_hi = 1'b1;
    end
    chk("und gap low", saw_hi, 0);
    chk("und count", und_cnt - u0, 1);
    send(24'hC3A501, 1'b1, 1'b0, 50);
    chk("und gap dout0", dout, 0);
    @(negedge ACLK);
    chk("und gap dout1", dout, 1);
    run_pixel(24'hC3A501, "und p2");
    finish_frame("und", 5000);
    @(negedge ACLK);

    // Back-pressure with s_valid held high
    u0 = und_cnt;
    send(24'h112233, 1'b0, 1'b1, 50);
    c1 = cyc;
    send(24'h445566, 1'b0, 1'b1, 4000);
    c2 = cyc;
    send(24'h778899, 1'b1, 1'b0, 4000);
    c3 = cyc;
    chk("bp gap 1-2", c2 - c1, 2);
    chk("bp gap 2-3", c3 - c2, 3000);
    n = 0;
    while (frame_done !== 1'b1 && n < 12000) begin
      @(negedge ACLK);
      n++;
    end
    chk("bp frame end", n, 10999);
    chk("bp underrun", und_cnt - u0, 0);
    @(negedge ACLK);

    // Reset in the middle of a 1-bit high phase, with a second pixel held
    send(24'h800000, 1'b0, 1'b0, 50);
    send(24'hFFFFFF, 1'b0, 1'b0, 50);
    repeat (10) @(negedge ACLK);
    chk("mid high", dout, 1);
    ARESET = 1'b1;
    #1;
    chk("arst dout", dout, 0);
    chk("arst s_ready", s_ready, 0);
    chk("arst busy", busy, 0);
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("arst rel ready", s_ready, 1);
    repeat (5) @(negedge ACLK);
    chk("arst no residue dout", dout, 0);
    chk("arst no residue busy", busy, 0);
    send(24'h000001, 1'b1, 1'b0, 50);
    @(negedge ACLK);
    run_pixel(24'h000001, "arst px");
    finish_frame("arst", 5000);
    @(negedge ACLK);

    // Pixel offered during LATCH
    send(24'h000080, 1'b1, 1'b0, 50);
    @(negedge ACLK);
    run_pixel(24'h000080, "latch pA");
    chk("latch busy", busy, 1);
    send(24'hFFFFFF, 1'b1, 1'b0, 50);
    finish_frame("latch pA", 4999);
    chk("latch next dout", dout, 1);
    chk("latch busy at fd", busy, 1);
    run_pixel(24'hFFFFFF, "latch pB");
    finish_frame("latch pB", 5000);
    chk("latch pB idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
